fetch_align_queue: RTL and testbench

//  Halfword-granular instruction queue between Icache fetch and decode (IF/ID boundary).

---
 rtl/fetch_align_queue_pkg.sv | 16 +
 rtl/fetch_align_queue_hw_ring_buf.sv | 37 +++
 rtl/fetch_align_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_align_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_queue_pkg.sv
// Shared widths, defaults and the RVC length test for the fetch alignment queue.
// A halfword whose two low bits are not 2'b11 starts a 16-bit compressed instruction.
package fetch_align_queue_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam logic [31:0] DEF_START_PC   = 32'h0000_0000;
    localparam int unsigned INST_WIDTH     = 32;
    localparam int unsigned HW_WIDTH       = 16;
    // Read window: enough halfwords for two 32-bit instructions
    localparam int unsigned WIN_HW         = 4;

    function automatic logic isRvc(input logic [1:0] lowBits);
        return lowBits != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_queue_hw_ring_buf.sv
// Halfword ring storage: one FETCH_HW-wide write port, and a WIN_HW-halfword read window
// starting at rdPtr that wraps around the end of the ring.
module fetch_align_queue_hw_ring_buf
    import fetch_align_queue_pkg::*;
#(
    parameter int unsigned DEPTH_HW = 16,
    parameter int unsigned FETCH_HW = 4
) (
    input  logic                         clk,
    input  logic                         wrEn,
    input  logic [$clog2(DEPTH_HW)-1:0]  wrPtr,
    input  logic [HW_WIDTH*FETCH_HW-1:0] wrData,
    input  logic [$clog2(DEPTH_HW)-1:0]  rdPtr,
    output logic [HW_WIDTH*WIN_HW-1:0]   rdWindow
);

    localparam int unsigned PTR_W = $clog2(DEPTH_HW);

    logic [HW_WIDTH-1:0] mem [DEPTH_HW];

    // Storage is intentionally not reset; valid tracking lives in the top level
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < FETCH_HW; k++) begin
                mem[wrPtr + PTR_W'(k)] <= wrData[k*HW_WIDTH +: HW_WIDTH];
            end
        end
    end

    always_comb begin
        rdWindow = '0;
        for (int k = 0; k < WIN_HW; k++) begin
            rdWindow[k*HW_WIDTH +: HW_WIDTH] = mem[rdPtr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/fetch_align_queue.sv
// Halfword-granular IF/ID instruction queue: realigns mixed RVC/32-bit instructions from
// 4-halfword fetch packets and presents up to two per cycle with their PCs.
module fetch_align_queue
    import fetch_align_queue_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH_HW   = 16,
    parameter int unsigned FETCH_HW   = 4,
    parameter logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(DEF_START_PC)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        flush_pc,
    input  logic                         fetch_valid,
    output logic                         fetch_ready,
    input  logic [ADDR_WIDTH-1:0]        fetch_pc,
    input  logic [HW_WIDTH*FETCH_HW-1:0] fetch_data,
    output logic                         inst0_valid,
    output logic [INST_WIDTH-1:0]        inst0,
    output logic [ADDR_WIDTH-1:0]        inst0_pc,
    output logic                         inst0_rvc,
    output logic                         inst1_valid,
    output logic [INST_WIDTH-1:0]        inst1,
    output logic [ADDR_WIDTH-1:0]        inst1_pc,
    output logic                         inst1_rvc,
    input  logic [1:0]                   dec_take,
    output logic [ADDR_WIDTH-1:0]        head_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH_HW);
    localparam int unsigned CNT_W = $clog2(DEPTH_HW + 1);

    logic [PTR_W-1:0]      rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
    logic [CNT_W-1:0]      countQ, countD;
    logic [ADDR_WIDTH-1:0] headPcQ, headPcD;

    logic [HW_WIDTH*WIN_HW-1:0] window;
    logic [HW_WIDTH-1:0]        hw [WIN_HW];
    logic [HW_WIDTH-1:0]        hwA, hwB;
    logic                       rvc0, rvc1;
    logic [2:0]                 len0, len1, popHw;
    logic [ADDR_WIDTH-1:0]      expectPc;
    logic                       push, restart;

    fetch_align_queue_hw_ring_buf #(
        .DEPTH_HW (DEPTH_HW),
        .FETCH_HW (FETCH_HW)
    ) uRingBuf (
        .clk      (clk),
        .wrEn     (push),
        .wrPtr    (wrPtrQ),
        .wrData   (fetch_data),
        .rdPtr    (rdPtrQ),
        .rdWindow (window)
    );

    // Alignment: inst1 begins one or two halfwords after the head depending on inst0 length
    always_comb begin
        for (int k = 0; k < WIN_HW; k++) begin
            hw[k] = window[k*HW_WIDTH +: HW_WIDTH];
        end
        rvc0 = isRvc(hw[0][1:0]);
        len0 = rvc0 ? 3'd1 : 3'd2;
        hwA  = rvc0 ? hw[1] : hw[2];
        hwB  = rvc0 ? hw[2] : hw[3];
        rvc1 = isRvc(hwA[1:0]);
        len1 = rvc1 ? 3'd1 : 3'd2;
    end

    always_comb begin
        inst0_valid = (countQ != '0) && (rvc0 || countQ >= CNT_W'(2));
        inst1_valid = inst0_valid && (countQ >= CNT_W'(len0) + CNT_W'(1))
                      && (rvc1 || countQ >= CNT_W'(len0) + CNT_W'(2));
        inst0       = rvc0 ? {16'h0000, hw[0]} : {hw[1], hw[0]};
        inst1       = rvc1 ? {16'h0000, hwA} : {hwB, hwA};
        inst0_rvc   = rvc0;
        inst1_rvc   = rvc1;
        inst0_pc    = headPcQ;
        inst1_pc    = headPcQ + (rvc0 ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
        head_pc     = headPcQ;
        fetch_ready = (CNT_W'(DEPTH_HW) - countQ) >= CNT_W'(FETCH_HW);
    end

    // Over-asking decode is saturated to whatever is actually complete
    always_comb begin
        if (dec_take >= 2'd2 && inst1_valid) begin
            popHw = len0 + len1;
        end else if (dec_take != 2'd0 && inst0_valid) begin
            popHw = len0;
        end else begin
            popHw = 3'd0;
        end
    end

    always_comb begin
        expectPc = headPcQ + ADDR_WIDTH'({countQ, 1'b0});
        push     = fetch_valid && fetch_ready && !flush;
        // An empty queue or a non-contiguous packet both restart the queue at fetch_pc
        restart  = push && (countQ == '0 || fetch_pc != expectPc);
    end

    always_comb begin
        rdPtrD  = rdPtrQ;
        wrPtrD  = wrPtrQ;
        countD  = countQ;
        headPcD = headPcQ;
        if (flush) begin
            rdPtrD  = '0;
            wrPtrD  = '0;
            countD  = '0;
            headPcD = flush_pc;
        end else if (restart) begin
            rdPtrD  = wrPtrQ;
            wrPtrD  = wrPtrQ + PTR_W'(FETCH_HW);
            countD  = CNT_W'(FETCH_HW);
            headPcD = fetch_pc;
        end else begin
            rdPtrD  = rdPtrQ + PTR_W'(popHw);
            countD  = countQ - CNT_W'(popHw);
            headPcD = headPcQ + ADDR_WIDTH'({popHw, 1'b0});
            if (push) begin
                wrPtrD = wrPtrQ + PTR_W'(FETCH_HW);
                countD = countQ - CNT_W'(popHw) + CNT_W'(FETCH_HW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtrQ  <= '0;
            wrPtrQ  <= '0;
            countQ  <= '0;
            headPcQ <= START_PC;
        end else begin
            rdPtrQ  <= rdPtrD;
            wrPtrQ  <= wrPtrD;
            countQ  <= countD;
            headPcQ <= headPcD;
        end
    end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue: a halfword-list model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_fetch_align_queue;
    import fetch_align_queue_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          FH    = 4;
    localparam logic [31:0] START = 32'h0000_0000;

    localparam logic [63:0] T1D  = 64'h00B0_0113_00A0_0093;
    localparam logic [63:0] T2D  = 64'h4585_00A0_0093_4505;
    localparam logic [63:0] RVC4 = 64'h4501_4501_4501_4501;
    localparam logic [63:0] STR  = 64'h0093_4501_4501_4501;
    localparam logic [63:0] NXT  = 64'h4501_4501_4501_00A0;
    localparam logic [63:0] EXT  = 64'h4505_4505_4505_4505;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_data;
    logic        inst0_valid, inst1_valid, inst0_rvc, inst1_rvc;
    logic [31:0] inst0, inst1, inst0_pc, inst1_pc, head_pc;
    logic [1:0]  dec_take;

    always #5 clk = ~clk;

    fetch_align_queue #(
        .ADDR_WIDTH (32),
        .DEPTH_HW   (DEPTH),
        .FETCH_HW   (FH),
        .START_PC   (START)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_data  (fetch_data),
        .inst0_valid (inst0_valid),
        .inst0       (inst0),
        .inst0_pc    (inst0_pc),
        .inst0_rvc   (inst0_rvc),
        .inst1_valid (inst1_valid),
        .inst1       (inst1),
        .inst1_pc    (inst1_pc),
        .inst1_rvc   (inst1_rvc),
        .dec_take    (dec_take),
        .head_pc     (head_pc)
    );

    int vectors = 0;
    int miscompares = 0;
    bit cmpEn = 1'b0;

    // Model: queue contents as an ordered list of halfwords plus the PC of the first one
    logic [15:0] mq[$];
    logic [31:0] mHead;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mRvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // Instruction starting at halfword offset idx, if fully present
    function automatic void mInst(input int idx, output bit v, output logic [31:0] ins,
                                  output int len);
        v = 1'b0;
        ins = '0;
        len = 0;
        if (idx < mq.size()) begin
            if (mRvc(mq[idx])) begin
                v = 1'b1;
                ins = {16'h0000, mq[idx]};
                len = 1;
            end else if (idx + 1 < mq.size()) begin
                v = 1'b1;
                ins = {mq[idx+1], mq[idx]};
                len = 2;
            end
        end
    endfunction

    function automatic void mStep(input bit fv, input logic [31:0] fpc, input logic [63:0] fd,
                                  input int take, input bit fl, input logic [31:0] flpc);
        bit          rdy, push, v;
        logic [31:0] ins;
        int          len, off;
        if (!rst_n) begin
            mq.delete();
            mHead = START;
        end else if (fl) begin
            mq.delete();
            mHead = flpc;
        end else begin
            rdy  = (DEPTH - mq.size()) >= FH;
            push = fv && rdy;
            if (push && (mq.size() == 0 || fpc != mHead + 32'(2 * mq.size()))) begin
                mq.delete();
                mHead = fpc;
            end else begin
                off = 0;
                for (int i = 0; i < take; i++) begin
                    mInst(off, v, ins, len);
                    if (!v) break;
                    off += len;
                end
                for (int i = 0; i < off; i++) void'(mq.pop_front());
                mHead += 32'(2 * off);
            end
            if (push) begin
                for (int k = 0; k < FH; k++) mq.push_back(fd[16*k +: 16]);
            end
        end
    endfunction

    always @(negedge clk) begin : cmpProc
        bit          v0, v1;
        logic [31:0] i0, i1;
        int          l0, l1;
        if (cmpEn) begin
            mInst(0, v0, i0, l0);
            v1 = 1'b0;
            i1 = '0;
            l1 = 0;
            if (v0) mInst(l0, v1, i1, l1);
            chk("fetch_ready", fetch_ready, (DEPTH - mq.size()) >= FH);
            chk("head_pc", head_pc, mHead);
            chk("inst0_valid", inst0_valid, v0);
            chk("inst1_valid", inst1_valid, v1);
            if (v0) begin
                chk("inst0", inst0, i0);
                chk("inst0_pc", inst0_pc, mHead);
                chk("inst0_rvc", inst0_rvc, l0 == 1);
            end
            if (v1) begin
                chk("inst1", inst1, i1);
                chk("inst1_pc", inst1_pc, mHead + 32'(2 * l0));
                chk("inst1_rvc", inst1_rvc, l1 == 1);
            end
        end
    end

    task automatic step(input bit fv, input logic [31:0] fpc, input logic [63:0] fd,
                        input int take, input bit fl = 1'b0, input logic [31:0] flpc = 32'h0);
        fetch_valid = fv;
        fetch_pc    = fpc;
        fetch_data  = fd;
        dec_take    = 2'(take);
        flush       = fl;
        flush_pc    = flpc;
        @(posedge clk);
        mStep(fv, fpc, fd, take, fl, flpc);
        @(negedge clk);
        #1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        dec_take    = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc = '0;
        fetch_data = '0;
        dec_take = 2'd0;
        flush = 1'b0;
        flush_pc = '0;
        mHead = START;
        @(negedge clk);
        step(1'b0, 32'h0, 64'h0, 0);
        cmpEn = 1'b1;
        step(1'b0, 32'h0, 64'h0, 0);
        rst_n = 1'b1;
        chk("rst_inst0_valid", inst0_valid, 1'b0);
        chk("rst_fetch_ready", fetch_ready, 1'b1);
        chk("rst_head_pc", head_pc, START);

        // Two 32-bit instructions
        step(1'b1, 32'h100, T1D, 0);
        chk("t1_inst0_valid", inst0_valid, 1'b1);
        chk("t1_inst1_valid", inst1_valid, 1'b1);
        chk("t1_inst0", inst0, 32'h00A0_0093);
        chk("t1_inst1", inst1, 32'h00B0_0113);
        chk("t1_inst0_pc", inst0_pc, 32'h100);
        chk("t1_inst1_pc", inst1_pc, 32'h104);
        chk("t1_rvc", {inst0_rvc, inst1_rvc}, 2'b00);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t1_drained", inst0_valid, 1'b0);
        chk("t1_head_pc", head_pc, 32'h108);

        // Mixed RVC / 32-bit
        step(1'b1, 32'h200, T2D, 0);
        chk("t2_inst0", inst0, 32'h0000_4505);
        chk("t2_inst0_rvc", inst0_rvc, 1'b1);
        chk("t2_inst1", inst1, 32'h00A0_0093);
        chk("t2_inst1_pc", inst1_pc, 32'h202);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t2_head_pc", head_pc, 32'h206);
        chk("t2_inst0", inst0, 32'h0000_4585);
        chk("t2_inst0_valid", inst0_valid, 1'b1);
        chk("t2_inst1_valid", inst1_valid, 1'b0);

        // Straddling 32-bit instruction across the ring wrap
        step(1'b1, 32'h208, RVC4, 1);
        step(1'b1, 32'h210, STR, 2);
        step(1'b0, 32'h0, 64'h0, 2);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t3_head_pc", head_pc, 32'h214);
        chk("t3_inst1_half", inst1_valid, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1);
        chk("t3_inst0_half", inst0_valid, 1'b0);
        step(1'b0, 32'h0, 64'h0, 0);
        chk("t3_inst0_still_half", inst0_valid, 1'b0);
        step(1'b1, 32'h218, NXT, 0);
        chk("t3_inst0_valid", inst0_valid, 1'b1);
        chk("t3_inst0", inst0, 32'h00A0_0093);
        chk("t3_inst0_pc", inst0_pc, 32'h216);
        chk("t3_inst1", inst1, 32'h0000_4501);
        chk("t3_inst1_pc", inst1_pc, 32'h21A);
        step(1'b0, 32'h0, 64'h0, 2);

        // Fill to full, then drain one pair
        step(1'b0, 32'h0, 64'h0, 0, 1'b1, 32'h1000);
        for (int p = 0; p < 4; p++) step(1'b1, 32'h1000 + 32'(8 * p), T1D, 0);
        chk("t4_full_ready", fetch_ready, 1'b0);
        chk("t4_full_valid", inst0_valid, 1'b1);
        step(1'b1, 32'h1020, EXT, 0);
        chk("t4_ignored_ready", fetch_ready, 1'b0);
        chk("t4_ignored_head", head_pc, 32'h1000);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t4_ready_again", fetch_ready, 1'b1);
        chk("t4_head_pc", head_pc, 32'h1008);

        // Flush beats push and pop
        step(1'b1, 32'h1020, EXT, 2, 1'b1, 32'h8000);
        chk("t5_inst0_valid", inst0_valid, 1'b0);
        chk("t5_head_pc", head_pc, 32'h8000);
        chk("t5_ready", fetch_ready, 1'b1);
        step(1'b0, 32'h0, 64'h0, 0);
        chk("t5_dropped", inst0_valid, 1'b0);

        // Discontinuity restarts the queue at the new packet
        step(1'b0, 32'h0, 64'h0, 0, 1'b1, 32'h2FC);
        step(1'b1, 32'h2FC, RVC4, 0);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t6_head_pc_before", head_pc, 32'h300);
        step(1'b1, 32'h400, T1D, 0);
        chk("t6_head_pc", head_pc, 32'h400);
        chk("t6_inst0", inst0, 32'h00A0_0093);
        chk("t6_inst1_pc", inst1_pc, 32'h404);
        step(1'b0, 32'h0, 64'h0, 2);
        chk("t6_only_new", inst0_valid, 1'b0);

        // Reset mid-stream
        step(1'b1, 32'h500, RVC4, 0);
        rst_n = 1'b0;
        step(1'b1, 32'h508, RVC4, 1);
        rst_n = 1'b1;
        chk("rst2_valids", {inst0_valid, inst1_valid}, 2'b00);
        chk("rst2_head_pc", head_pc, START);
        chk("rst2_ready", fetch_ready, 1'b1);

        cmpEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
